uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter; the transmit half of the serial link. Takes an 8-bit byte on a
//   one-cycle start strobe. Serialises it LSB-first on tx: start bit, 8 data bits,
//   optional even parity bit, stop bit. Sits between the core's MMIO/UART register
//   block and the board TX pin. Line format matches the on-chip UART receiver.
// PARAMETERS
//   CLK_FREQ   25_000_000  system clock frequency in Hz
//   BAUD       9600        line baud rate in bits/s
//   BIT_COUNTS CLK_FREQ/BAUD (2604)  clocks per bit; derived localparam, must be >= 2
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  reset; asynchronous, active-high
//   tx_start   in   1  one-cycle request to send tx_data; honoured only when !tx_busy
//   tx_data    in   8  byte to send; sampled in the cycle tx_start is accepted
//   tx         out  1  serial line; idles high
//   tx_busy    out  1  high from the cycle after acceptance until the stop bit ends
//   tx_done    out  1  one-cycle pulse when the stop bit has been held BIT_COUNTS clocks
// BEHAVIOUR
//   Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE.
//     Bit counter, baud counter and data shift register all reset to 0.
//   FSM states and transitions:
//     IDLE   -> START  on tx_start; latch tx_data into shift reg; clear baud counter.
//     START  -> DATA   tx=0 for BIT_COUNTS clocks.
//     DATA   -> PARITY (or STOP) after 8 bit-times. tx=shreg[0]; shift right at each
//       bit end; bit counter runs 0..7.
//     PARITY -> STOP   tx=^latched_data (even parity) for BIT_COUNTS clocks.
//     STOP   -> IDLE   tx=1 for BIT_COUNTS clocks; tx_done=1 in the transition cycle.
//   Latency: tx falls on the clock edge after tx_start is accepted.
//   Frame length: 10*BIT_COUNTS clocks, or 11*BIT_COUNTS with parity; no extra cycles.
//   The baud counter counts 0..BIT_COUNTS-1. The bit ends at the terminal count,
//     then the counter wraps to 0. It runs only when state != IDLE.
//   tx_start while tx_busy=1 is ignored; no queueing, and the in-flight frame is
//     not disturbed. tx_data changes mid-frame have no effect.
//   Back-to-back: tx_start asserted in the same cycle as tx_done is not accepted,
//     since the FSM is still in STOP. It is accepted on the following cycle.
//     Minimum frame-to-frame gap is 1 clock of idle-high.
//   tx_busy = (state != IDLE); registered, glitch-free.
//   tx is registered (driven from a flop) so the pin never glitches.
//   rst mid-frame: immediate return to IDLE with tx=1. A truncated frame goes onto
//     the line; no tx_done is produced for it.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state present; frame is 8E1 (11 bits).
//     This matches the 9-bit (data+parity) capture of the on-chip receiver.
//   Not defined: PARITY state removed; DATA -> STOP directly; frame is 8N1 (10 bits).
// STRUCTURE
//   uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP, 3-bit encoding),
//     UART_DATA_W=8, and a function bit_counts(clk_freq, baud).
//   Sub-module uart_baud_tick: parameter BIT_COUNTS; inputs clk, rst, enable;
//     output bit_end pulse. Free-running counter that clears while !enable.
//   uart_tx holds the FSM, the bit counter, the 8-bit shift register and the
//     parity flop.
// TESTING (sim with CLK_FREQ=16, BAUD=1 -> BIT_COUNTS=16)
//   Reset: rst=1 mid-run -> tx=1, tx_busy=0, tx_done=0 immediately (async).
//     These values hold after release.
//   Send 0xA5 (parity on) -> tx=0 for 16 clk, then bits 1,0,1,0,0,1,0,1, then
//     parity 0, then stop 1. tx_done pulses at clock 176 after acceptance.
//   Send 0x01 with UART_TX_PARITY_EN undefined -> 160-clk frame, no parity slot.
//     tx_done pulses at clock 160.
//   tx_start with 0xFF at clock 40 of a 0x00 frame -> the 0x00 frame completes
//     unchanged; 0xFF is never sent; exactly one tx_done.
//   tx_start held high across tx_done -> next frame's start bit begins 1 clk after
//     tx_done; exactly 1 idle-high clock between frames.
//   Loopback of tx into the UART receiver, 0x00..0xFF at 9600 baud / 25 MHz ->
//     every received byte and parity matches the byte sent.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - state_t      : transmitter FSM states, 3-bit encoding
//   - UART_DATA_W  : payload width (8 bits)
//   - bit_counts() : clocks per bit for a given clock frequency and baud rate
//
//   Optional feature macro used by the importing RTL: UART_TX_PARITY_EN.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int UART_DATA_W = 8;

    function automatic int bit_counts(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-time counter for the UART transmitter. Counts 0..BIT_COUNTS-1 while
//   enabled and is held at 0 while disabled.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   enable   in   count while high, clear while low
//   bit_end  out  high in the last clock of each bit time (terminal count)
//   bit_pre  out  high in the clock before bit_end (lets the caller register
//                 an output that must be valid during the terminal clock)
//
// BIT_COUNTS must be >= 2 so that bit_pre and bit_end fall in distinct clocks.
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int BIT_COUNTS = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_end,
    output logic bit_pre
);

    localparam int CW = (BIT_COUNTS > 1) ? $clog2(BIT_COUNTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_COUNTS - 1);
    localparam logic [CW-1:0] PRE  = CW'(BIT_COUNTS - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = enable && (cnt == LAST);
    assign bit_pre = enable && (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Sends one byte per accepted tx_start, LSB first:
//   start bit (0), 8 data bits, optional even parity bit, stop bit (1).
//
//   Build option: define UART_TX_PARITY_EN for 8E1 frames (11 bits);
//   leave it undefined for 8N1 frames (10 bits).
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tx_start  in   one-cycle send request, honoured only while tx_busy=0
//   tx_data   in   byte to send, sampled in the accepting cycle
//   tx        out  serial line, idles high, registered
//   tx_busy   out  high while a frame is in flight (state != IDLE)
//   tx_done   out  one-cycle pulse in the final clock of the stop bit
//   state     out  current FSM state, for observation only
//
// Handshake: a request is taken in the cycle where tx_start=1 and the FSM is
// IDLE; tx_busy rises on the following edge and requests are ignored (not
// queued) until the FSM is back in IDLE.
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done,
    output state_t                 state
);

    localparam int BIT_COUNTS = bit_counts(CLK_FREQ, BAUD);

    logic                   bit_end;
    logic                   bit_pre;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    uart_baud_tick #(
        .BIT_COUNTS(BIT_COUNTS)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .enable  (state != IDLE),
        .bit_end (bit_end),
        .bit_pre (bit_pre)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // tx_done is loaded one clock early so that, as a registered
            // output, it is high during the terminal clock of the stop bit
            // while the FSM is still in STOP.
            tx_done <= (state == STOP) && bit_pre;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        state      <= START;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        bit_cnt    <= '0;
                        shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shreg[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
//   Each frame's expected line waveform is built from the byte as a queue of
//   line bits (start, data LSB first, optional even parity, stop) and every
//   clock of the frame is compared against bit index = cycle / 16.
// ----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BITC = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * BITC;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    state_t     dut_state;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .state    (dut_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line bits for one frame, in transmission order.
    task automatic build_frame(input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'((d >> i) & 8'd1));
`ifdef UART_TX_PARITY_EN
        begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
            exp_q.push_back(1'(ones % 2));
        end
`endif
        exp_q.push_back(1'b1);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. Requests byte d, then checks
    // every clock of the frame plus the idle clock after it. At cycle
    // 'intrude' a 0xFF request is injected (must be ignored). With 'hold'
    // set, tx_start stays high for the whole frame and beyond.
    task automatic send(input logic [7:0] d, input int intrude, input bit hold);
        build_frame(d);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            check("tx_line", 32'(tx), 32'(exp_q[k / BITC]));
            check("tx_busy", 32'(tx_busy), 32'd1);
            check("tx_done", 32'(tx_done), (k == FRAME_CLKS - 1) ? 32'd1 : 32'd0);
            if (k == intrude) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                if (!hold) tx_start = 1'b0;
                tx_data = 8'($urandom);
            end
            @(negedge clk);
        end
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(tx_busy), 32'd0);
        check("idle_done", 32'(tx_done), 32'd0);
    endtask

    task automatic idle(input int n);
        tx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_tx", 32'(tx), 32'd1);
            check("gap_busy", 32'(tx_busy), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        rst = 1'b0;
        idle(3);

        // directed frames
        send(8'hA5, -1, 1'b0);
        idle(2);
        send(8'h01, -1, 1'b0);
        idle(1);
        // request during a 0x00 frame is dropped
        send(8'h00, 40, 1'b0);
        idle(4);

        // tx_start held high across tx_done: one idle clock between frames
        send(8'h3C, -1, 1'b1);
        send(8'hC3, -1, 1'b1);
        send(8'h80, -1, 1'b0);
        idle(2);

        // random bytes, random gaps, random intrusions
        for (int n = 0; n < 12; n++) begin
            send(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_CLKS - 2)) : -1,
                 1'b0);
            idle($urandom_range(0, 3));
        end

        // asynchronous reset in the middle of a frame (during a 0 data bit)
        tx_start = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_busy", 32'(tx_busy), 32'd0);
        check("arst_done", 32'(tx_done), 32'd0);
        check("arst_state", 32'(dut_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        // truncated frame yields no tx_done and the line stays idle
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (i % 8 == 0) begin
                check("post_rst_tx", 32'(tx), 32'd1);
                check("post_rst_busy", 32'(tx_busy), 32'd0);
            end
            check("post_rst_done", 32'(tx_done), 32'd0);
        end

        // normal operation resumes after reset
        send(8'h5A, -1, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
